// File: rtl/gain_n_multi.sv
// gain_n_multi: per-channel fixed-point gain on an interleaved stream, with round-half-up, saturation and a FWFT output FIFO.
//   clock/reset(async, active-low); din/in_wr_en/in_full: credit-guarded input write port;
//   dout/out_ch/out_empty/out_rd_en: first-word-fall-through output port with channel tag;
//   cfg_wr_en/cfg_ch/cfg_gain: run-time gain write; sat_count: sticky-at-max count of clipped results.
module gain_n_multi #(
  parameter int DATA_WIDTH   = 32,
  parameter int GAIN_WIDTH   = 16,
  parameter int FRAC_BITS    = 10,
  parameter int CHANNELS     = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int DEFAULT_GAIN = 1 << FRAC_BITS,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_rd_en,
  output logic                  out_empty,
  output logic [CW-1:0]         out_ch,
  input  logic                  cfg_wr_en,
  input  logic [CW-1:0]         cfg_ch,
  input  logic [GAIN_WIDTH-1:0] cfg_gain,
  output logic [15:0]           sat_count
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  // Half an LSB of the result; evaluates to zero when there are no fractional bits.
  localparam logic signed [PW:0] RND = ((PW+1)'(1) << FRAC_BITS) >> 1;
  logic signed [GAIN_WIDTH-1:0] gain [CHANNELS];
  logic [CW-1:0] ch_cnt, c1, c2, c3;
  logic v1, v2, v3;
  logic signed [DATA_WIDTH-1:0] d1;
  logic signed [GAIN_WIDTH-1:0] g1;
  logic signed [PW-1:0] p2;
  logic [DATA_WIDTH-1:0] r3, sat_val;
  logic signed [PW:0] rnd;
  logic clip, accept, pop;
  logic [CW+DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  // Credits cover both buffered and in-flight samples, so the non-stalling pipeline can never overflow the FIFO.
  assign in_full = ({1'b0, cnt} + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3)) >= (AW+2)'(FIFO_DEPTH);
  assign accept = in_wr_en && !in_full;
  assign out_empty = cnt == '0;
  assign pop = out_rd_en && !out_empty;
  assign dout = out_empty ? '0 : mem[rp][DATA_WIDTH-1:0];
  assign out_ch = out_empty ? '0 : mem[rp][CW+DATA_WIDTH-1:DATA_WIDTH];
  always_comb begin
    rnd = ($signed({p2[PW-1], p2}) + RND) >>> FRAC_BITS;
    // Result fits only when every bit above the output sign bit matches it.
    clip = !(&rnd[PW:DATA_WIDTH-1] || ~|rnd[PW:DATA_WIDTH-1]);
    sat_val = clip ? {rnd[PW], {(DATA_WIDTH-1){!rnd[PW]}}} : rnd[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset)
      for (int i = 0; i < CHANNELS; i++) gain[i] <= GAIN_WIDTH'(DEFAULT_GAIN);
    else if (cfg_wr_en && 32'(cfg_ch) < CHANNELS)
      gain[cfg_ch] <= cfg_gain;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {v1, v2, v3} <= '0;
      {c1, c2, c3, ch_cnt} <= '0;
      d1 <= '0;
      g1 <= '0;
      p2 <= '0;
      r3 <= '0;
      sat_count <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      c2 <= c1;
      c3 <= c2;
      if (accept) begin
        d1 <= din;
        c1 <= ch_cnt;
        g1 <= gain[ch_cnt];
        ch_cnt <= ch_cnt == CW'(CHANNELS-1) ? '0 : ch_cnt + 1'b1;
      end
      p2 <= PW'(d1) * PW'(g1);
      r3 <= sat_val;
      if (v2 && clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(v3);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(v3) - (AW+1)'(pop);
    end
  always_ff @(posedge clock)
    if (v3) mem[wp] <= {c3, r3};
endmodule

// File: tb/tb_gain_n_multi.sv
// tb_gain_n_multi: directed scoreboard bench for gain_n_multi at default parameters.
module tb_gain_n_multi;
  logic clock, reset;
  logic [31:0] din, dout;
  logic in_wr_en, in_full, out_rd_en, out_empty, cfg_wr_en;
  logic [0:0] out_ch, cfg_ch;
  logic [15:0] cfg_gain, sat_count;
  int tests, fails, acc, msat;
  logic [32:0] q [$];
  logic [15:0] mg [2];
  logic mc;

  gain_n_multi dut (
    .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full),
    .dout(dout), .out_rd_en(out_rd_en), .out_empty(out_empty), .out_ch(out_ch),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .sat_count(sat_count)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl(input logic [31:0] d, input logic [15:0] g, output bit c);
    longint p, r;
    p = longint'($signed(d)) * longint'($signed(g));
    r = (p + 64'sd512) >>> 10;
    c = 0;
    if (r > 64'sd2147483647) begin c = 1; r = 64'sd2147483647; end
    else if (r < -64'sd2147483648) begin c = 1; r = -64'sd2147483648; end
    return r[31:0];
  endfunction

  // One clock: drive at a negedge, predict what the next posedge does, advance to the following negedge.
  task automatic step(input bit wr, input logic [31:0] d, input bit rd,
                      input bit cw = 0, input bit cc = 0, input logic [15:0] cg = 0);
    logic [31:0] e;
    logic [32:0] h;
    bit c;
    in_wr_en = wr; din = d; out_rd_en = rd; cfg_wr_en = cw; cfg_ch = cc; cfg_gain = cg;
    if (wr && !in_full) begin
      e = mdl(d, mg[mc], c);
      q.push_back({mc, e});
      msat += int'(c);
      acc++;
      mc = !mc;
    end
    if (rd && !out_empty) begin
      tests++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_out: observed ch%0d %0h expected nothing", out_ch, dout);
      end
      if (q.size() > 0) begin
        h = q.pop_front();
        chk("out", {31'd0, out_ch, dout}, {31'd0, h});
      end
    end
    if (cw) mg[cc] = cg;
    @(negedge clock);
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 64 && q.size() > 0; i++) step(0, 0, 1);
    chk({tag, "_left"}, 64'(q.size()), 0);
    repeat (4) step(0, 0, 1);
    chk({tag, "_empty"}, 64'(out_empty), 1);
    chk({tag, "_sat"}, 64'(sat_count), 64'(msat));
  endtask

  initial begin
    tests = 0; fails = 0; acc = 0; msat = 0; mc = 0;
    mg[0] = 16'd1024; mg[1] = 16'd1024;
    reset = 0; din = 0; in_wr_en = 0; out_rd_en = 0; cfg_wr_en = 0; cfg_ch = 0; cfg_gain = 0;
    @(negedge clock);
    chk("rst_empty", 64'(out_empty), 1);
    chk("rst_full", 64'(in_full), 0);
    chk("rst_sat", 64'(sat_count), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_ch", 64'(out_ch), 0);
    reset = 1;
    @(negedge clock);

    step(1, 32'h00001000, 0);
    chk("lat_k0", 64'(out_empty), 1);
    step(0, 0, 0);
    chk("lat_k1", 64'(out_empty), 1);
    step(0, 0, 0);
    chk("lat_k2", 64'(out_empty), 1);
    step(0, 0, 0);
    chk("lat_k3", 64'(out_empty), 0);
    for (int i = 1; i < 100; i++) step(1, i == 1 ? 32'hFFFFF000 : $urandom, 1);
    drain("unity");
    chk("unity_sat0", 64'(sat_count), 0);

    if (mc) step(1, 32'h55, 1);
    step(0, 0, 0, 1, 0, 16'd2048);
    step(0, 0, 0, 1, 1, 16'd512);
    step(1, 32'h00001000, 0);
    step(1, 32'h00001000, 0);
    drain("perch");

    step(0, 0, 0, 1, 0, 16'd512);
    step(0, 0, 0, 1, 1, 16'd512);
    step(1, 32'h00000003, 0);
    step(1, 32'hFFFFFFFD, 0);
    drain("round");
    step(0, 0, 0, 1, 0, 16'd2048);
    step(0, 0, 0, 1, 1, 16'd2048);
    step(1, 32'h7FFFFFF0, 0);
    step(1, 32'h80000000, 0);
    drain("sat");
    chk("sat_two", 64'(sat_count), 2);
    step(0, 0, 0, 1, 0, 16'hFC00);
    step(0, 0, 0, 1, 1, 16'hFC00);
    step(1, 32'h80000000, 0);
    drain("neg");
    chk("sat_three", 64'(sat_count), 3);

    step(0, 0, 0, 1, 0, 16'd1024);
    step(0, 0, 0, 1, 1, 16'd1024);
    acc = 0;
    for (int i = 0; i < 20; i++) step(1, 32'h100 + i, 0);
    chk("bp_accepted", 64'(acc), 16);
    chk("bp_full", 64'(in_full), 1);
    chk("bp_nonempty", 64'(out_empty), 0);
    repeat (3) step(0, 0, 0);
    chk("bp_full_settled", 64'(in_full), 1);
    step(0, 0, 1);
    chk("bp_release", 64'(in_full), 0);
    drain("bp");

    if (mc) step(1, 32'h55, 1);
    step(1, 32'h00000100, 0, 1, 0, 16'd0);
    step(1, 32'h00000100, 0);
    step(1, 32'h00000100, 0);
    drain("coll");

    step(0, 0, 0, 1, 1, 16'd3000);
    for (int i = 0; i < 5; i++) step(1, 32'h2000 + i, 0);
    repeat (3) step(0, 0, 0);
    step(1, 32'h7000, 0);
    step(1, 32'h7001, 0);
    in_wr_en = 0; out_rd_en = 0; cfg_wr_en = 0;
    #2 reset = 0;
    #1;
    chk("mrst_empty", 64'(out_empty), 1);
    chk("mrst_full", 64'(in_full), 0);
    chk("mrst_sat", 64'(sat_count), 0);
    q.delete();
    mc = 0; msat = 0;
    mg[0] = 16'd1024; mg[1] = 16'd1024;
    @(negedge clock);
    reset = 1;
    step(1, 32'h00001000, 0);
    step(1, 32'h00001000, 0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
